// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, branch mode and fetch state encodings
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 16;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_JMR = 5'd18;
  localparam logic [4:0] OP_BZ  = 5'd19;
  localparam logic [4:0] OP_BNZ = 5'd20;
  localparam logic [4:0] OP_JMP = 5'd21;

  typedef enum logic [1:0] {
    MODE_BZ  = 2'd0,
    MODE_BNZ = 2'd1,
    MODE_JMP = 2'd2,
    MODE_JMR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - combinational branch decision and jump target
module branch_resolver
  import cpu_pkg::*;
(
  input  logic              J,
  input  logic [1:0]        MODE_SET,
  input  logic              ZERO,
  input  logic              OFFSET_SEL,
  input  logic [ADDR_W-1:0] IMM_OFFSET,
  input  logic [ADDR_W-1:0] REG_A,
  input  logic [ADDR_W-1:0] PC,
  output logic              taken,
  output logic [ADDR_W-1:0] next_pc
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (mode_e'(MODE_SET))
      MODE_BZ:  cond = ZERO;
      MODE_BNZ: cond = !ZERO;
      MODE_JMP: cond = 1'b1;
      MODE_JMR: cond = 1'b1;
      default:  cond = 1'b0;
    endcase
  end

  assign taken = J && cond;

  // next_pc is the jump target; the sequential PC+1 path is chosen by the caller.
  assign next_pc = PC + (OFFSET_SEL ? REG_A : IMM_OFFSET);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction fetch and next-PC sequencing
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               HOLD,
  output logic [ADDR_W-1:0]  IMEM_ADDR,
  output logic               IMEM_REQ,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  input  logic               IMEM_VALID,
  output logic [INSTR_W-1:0] OP_CODE,
  output logic               OP_VALID,
  input  logic               J,
  input  logic [1:0]         MODE_SET,
  input  logic               OFFSET_SEL,
  input  logic [ADDR_W-1:0]  IMM_OFFSET,
  input  logic [ADDR_W-1:0]  REG_A,
  input  logic               ZERO,
  output logic [ADDR_W-1:0]  PC
);

  fetch_state_e       state;
  logic [INSTR_W-1:0] ir;
  logic               taken;
  logic [ADDR_W-1:0]  target;

  branch_resolver u_branch_resolver (
    .J          (J),
    .MODE_SET   (MODE_SET),
    .ZERO       (ZERO),
    .OFFSET_SEL (OFFSET_SEL),
    .IMM_OFFSET (IMM_OFFSET),
    .REG_A      (REG_A),
    .PC         (PC),
    .taken      (taken),
    .next_pc    (target)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
      PC    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: if (!HOLD) state <= ST_WAIT;
        ST_WAIT: begin
          if (IMEM_VALID) begin
            ir    <= IMEM_DATA;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          PC    <= taken ? target : PC + ADDR_W'(1);
          state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Request is masked while RST is held so the strobe stays low through reset.
  assign IMEM_REQ  = (state == ST_FETCH) && !HOLD && !RST;
  assign IMEM_ADDR = PC;
  assign OP_VALID  = (state == ST_EXEC);
  assign OP_CODE   = (state == ST_EXEC) ? ir : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HOLD = 1'b0;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic [31:0] IMEM_DATA = '0;
  logic        IMEM_VALID = 1'b0;
  logic [31:0] OP_CODE;
  logic        OP_VALID;
  logic        J = 1'b0;
  logic [1:0]  MODE_SET = '0;
  logic        OFFSET_SEL = 1'b0;
  logic [15:0] IMM_OFFSET = '0;
  logic [15:0] REG_A = '0;
  logic        ZERO = 1'b0;
  logic [15:0] PC;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int bad_nop = 0;
  bit mon_en = 1'b0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .HOLD       (HOLD),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_DATA  (IMEM_DATA),
    .IMEM_VALID (IMEM_VALID),
    .OP_CODE    (OP_CODE),
    .OP_VALID   (OP_VALID),
    .J          (J),
    .MODE_SET   (MODE_SET),
    .OFFSET_SEL (OFFSET_SEL),
    .IMM_OFFSET (IMM_OFFSET),
    .REG_A      (REG_A),
    .ZERO       (ZERO),
    .PC         (PC)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (OP_VALID === 1'b1) pulses++;
      if (OP_VALID !== 1'b1 && OP_CODE !== 32'h0) bad_nop++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // One full instruction starting in FETCH; lat = WAIT cycles until IMEM_VALID.
  task automatic instr(input string tag, input logic [15:0] exp_addr, input logic [31:0] word,
                       input int lat, input bit j, input logic [1:0] mode, input bit osel,
                       input logic [15:0] imm, input logic [15:0] rega, input bit zero,
                       input bit stray);
    int c0;
    int p0;
    #1;
    c0 = cyc;
    p0 = pulses;
    check({tag, "_req"}, {31'b0, IMEM_REQ}, 32'd1);
    check({tag, "_addr"}, {16'b0, IMEM_ADDR}, {16'b0, exp_addr});
    step();
    check({tag, "_req_wait"}, {31'b0, IMEM_REQ}, 32'd0);
    for (int k = 1; k < lat; k++) begin
      check({tag, "_opv_wait"}, {31'b0, OP_VALID}, 32'd0);
      step();
    end
    IMEM_VALID = 1'b1;
    IMEM_DATA  = word;
    step();
    IMEM_VALID = stray;
    IMEM_DATA  = ~word;
    J = j; MODE_SET = mode; OFFSET_SEL = osel; IMM_OFFSET = imm; REG_A = rega; ZERO = zero;
    check({tag, "_opv"}, {31'b0, OP_VALID}, 32'd1);
    check({tag, "_op"}, OP_CODE, word);
    step();
    IMEM_VALID = 1'b0;
    J = 1'b0; MODE_SET = '0; OFFSET_SEL = 1'b0; IMM_OFFSET = '0; REG_A = '0; ZERO = 1'b0;
    check({tag, "_cycles"}, cyc - c0, lat + 2);
    check({tag, "_pulses"}, pulses - p0, 32'd1);
    check({tag, "_opv_after"}, {31'b0, OP_VALID}, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    step();
    step();
    check("rst_pc", {16'b0, PC}, 32'h0);
    check("rst_addr", {16'b0, IMEM_ADDR}, 32'h0);
    check("rst_req", {31'b0, IMEM_REQ}, 32'd0);
    check("rst_opv", {31'b0, OP_VALID}, 32'd0);
    check("rst_op", OP_CODE, 32'h0);
    mon_en = 1'b1;
    RST = 1'b0;

    instr("seq0", 16'h0000, 32'h0000_0000, 1, 0, 2'd0, 0, 16'h0, 16'h0, 0, 0);
    instr("seq1", 16'h0001, 32'h1111_0001, 1, 0, 2'd0, 0, 16'h0, 16'h0, 0, 0);
    instr("seq2", 16'h0002, 32'h2222_0002, 1, 0, 2'd0, 0, 16'h0, 16'h0, 0, 0);
    instr("jmp5", 16'h0003, 32'hA000_0003, 1, 1, 2'd2, 0, 16'h0002, 16'h0, 0, 0);
    instr("bz_t", 16'h0005, 32'hB000_0005, 1, 1, 2'd0, 0, 16'hFFFE, 16'h0, 1, 0);
    instr("jmpb", 16'h0003, 32'hA100_0003, 1, 1, 2'd2, 0, 16'h0002, 16'h0, 0, 0);
    instr("bz_n", 16'h0005, 32'hB100_0005, 1, 1, 2'd0, 0, 16'hFFFE, 16'h0, 0, 0);
    instr("jmp10", 16'h0006, 32'hA200_0006, 1, 1, 2'd2, 0, 16'h0004, 16'h0, 0, 0);
    instr("bnz", 16'h000A, 32'hC000_000A, 1, 1, 2'd1, 0, 16'h0004, 16'h0, 0, 0);
    instr("jmpm4", 16'h000E, 32'hA300_000E, 1, 1, 2'd2, 0, 16'hFFFC, 16'h0, 0, 0);
    instr("jmr", 16'h000A, 32'hD000_000A, 1, 1, 2'd3, 1, 16'h0007, 16'h0010, 0, 0);
    instr("jmpff", 16'h001A, 32'hA400_001A, 1, 1, 2'd2, 0, 16'hFFE5, 16'h0, 0, 0);
    instr("wrap", 16'hFFFF, 32'hE000_FFFF, 1, 0, 2'd2, 0, 16'h0040, 16'h0, 0, 0);
    instr("jmpf0", 16'h0000, 32'hA500_0000, 1, 1, 2'd2, 0, 16'hFFF0, 16'h0, 0, 0);
    instr("jmpwr", 16'hFFF0, 32'hA600_FFF0, 1, 1, 2'd2, 0, 16'h0020, 16'h0, 0, 0);
    instr("stall", 16'h0010, 32'h5700_0010, 5, 0, 2'd0, 0, 16'h0, 16'h0, 0, 0);
    instr("stray", 16'h0011, 32'h5800_0011, 1, 0, 2'd0, 0, 16'h0, 16'h0, 0, 1);

    for (int k = 0; k < 3; k++) begin
      HOLD = 1'b1;
      #1;
      check("hold_req", {31'b0, IMEM_REQ}, 32'd0);
      check("hold_opv", {31'b0, OP_VALID}, 32'd0);
      step();
    end
    HOLD = 1'b0;
    instr("afthold", 16'h0012, 32'h5900_0012, 1, 0, 2'd0, 0, 16'h0, 16'h0, 0, 0);

    begin
      int p0;
      p0 = pulses;
      #1;
      check("rw_addr", {16'b0, IMEM_ADDR}, 32'h0013);
      step();
      RST = 1'b1;
      IMEM_VALID = 1'b1;
      IMEM_DATA = 32'hDEAD_BEEF;
      step();
      check("rw_pc", {16'b0, PC}, 32'h0);
      check("rw_opv", {31'b0, OP_VALID}, 32'd0);
      check("rw_req", {31'b0, IMEM_REQ}, 32'd0);
      RST = 1'b0;
      IMEM_VALID = 1'b0;
      #1;
      check("rw_fetch_req", {31'b0, IMEM_REQ}, 32'd1);
      check("rw_pulses", pulses - p0, 32'd0);
    end
    instr("postrst", 16'h0000, 32'h6000_0000, 1, 0, 2'd0, 0, 16'h0, 16'h0, 0, 0);

    check("nop_outside_exec", bad_nop, 32'd0);
    check("total_pulses", pulses, 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage directly upstream of `control_unit`. It holds the program counter and requests 32-bit instruction words from instruction memory. Each word is presented as `OP_CODE` for exactly one execute cycle. The unit then uses the decoder's jump controls (`J`, `MODE_SET`, `OFFSET_SEL`, `IMM_OFFSET`) together with the ALU zero flag and register A to choose the next PC.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `HOLD` in 1: when high in FETCH, no request is issued (debug/single-step hold).
- `IMEM_ADDR` out 16: instruction address, equal to PC.
- `IMEM_REQ` out 1: one-cycle read request strobe.
- `IMEM_DATA` in 32: returned instruction word.
- `IMEM_VALID` in 1: `IMEM_DATA` is valid this cycle.
- `OP_CODE` out 32: instruction to `control_unit`. Equals 0 (NOP) outside EXEC.
- `OP_VALID` out 1: high only in EXEC.
- `J` in 1: jump/branch instruction, from `control_unit`.
- `MODE_SET` in 2: 0=BZ, 1=BNZ, 2=JMP, 3=JMR.
- `OFFSET_SEL` in 1: 1 selects `REG_A` as offset, 0 selects `IMM_OFFSET`.
- `IMM_OFFSET` in 16: signed immediate offset.
- `REG_A` in 16: register-file A port value, signed.
- `ZERO` in 1: ALU zero flag for the current instruction.
- `PC` out 16: current program counter.

## Operation
- The unit has three states: FETCH, WAIT and EXEC.
- **FETCH**
  - If `HOLD` is 1, stay in FETCH with `IMEM_REQ` = 0.
  - Otherwise drive `IMEM_REQ` = 1 and `IMEM_ADDR` = PC for one cycle, then go to WAIT.
- **WAIT**
  - `IMEM_REQ` = 0.
  - When `IMEM_VALID` = 1, latch `IMEM_DATA` into the instruction register (IR) and go to EXEC.
  - Otherwise stay in WAIT indefinitely; there is no timeout.
- **EXEC**
  - `OP_CODE` = IR and `OP_VALID` = 1 for exactly one cycle. Register-file writes driven by `control_unit` therefore occur once per instruction.
  - Next-PC selection at the end of EXEC, then go to FETCH:
    - taken = `J` && ((MODE_SET==0 && ZERO) || (MODE_SET==1 && !ZERO) || MODE_SET==2 || MODE_SET==3).
    - If taken: PC = PC + (`OFFSET_SEL` ? `REG_A` : `IMM_OFFSET`), in 16-bit two's-complement arithmetic, wrapping modulo 2^16.
    - Otherwise: PC = PC + 1, with 16'hFFFF wrapping to 16'h0000.
  - `J` = 0 means sequential, whatever the value of `MODE_SET`. `MODE_SET`, `IMM_OFFSET` and `REG_A` are ignored in that case.
- **Stray responses:** `IMEM_VALID` in FETCH or EXEC is ignored.
- **Opcode 0:** treated as an ordinary instruction that advances the PC.

## Timing
- **Reset values:** state = FETCH, PC = `RESET_PC`, IR = 0, `OP_CODE` = 0, `OP_VALID` = 0, `IMEM_REQ` = 0, `IMEM_ADDR` = `RESET_PC`.
- **First request:** issued in the first cycle after `RST` deasserts, provided `HOLD` is 0.
- **Throughput:** minimum 3 cycles per instruction (FETCH, WAIT with `IMEM_VALID` in that cycle, EXEC). Each additional memory wait cycle adds one cycle.
- **Next-PC inputs:** the decoder's jump outputs and `ZERO` are combinational in the same EXEC cycle and are sampled on the EXEC→FETCH edge.
- **Reset mid-operation:** `RST` asserted in any state forces all reset values on the next edge. A pending response is abandoned; instruction memory shares `RST`.
- **Output registering:** `PC` and IR are registers. `OP_CODE`, `OP_VALID`, `IMEM_REQ` and `IMEM_ADDR` are decoded from state and registers.

## Structure
- **Shared package `cpu_pkg`:**
  - 5-bit opcode constants, including BZ=19, BNZ=20, JMP=21 and JMR=18.
  - `MODE_SET` encodings: BZ=0, BNZ=1, JMP=2, JMR=3.
  - The fetch state encoding.
  - Width constants: `INSTR_W`=32, `ADDR_W`=16.
- **Sub-module `branch_resolver`:** combinational. Inputs `J`, `MODE_SET`, `ZERO`, `OFFSET_SEL`, `IMM_OFFSET`, `REG_A`, `PC`. Outputs `taken` and `next_pc`. It is instantiated once in `fetch_unit`.

## Test plan
- **Reset and sequential fetch:** hold `RST` 2 cycles, memory with 1-cycle latency, `J` = 0 for 3 instructions → `IMEM_ADDR` sequence 0,1,2. One `OP_VALID` pulse every 3 cycles. `OP_CODE` = 0 outside EXEC.
- **BZ:** PC=5, `J`=1, `MODE_SET`=0, `IMM_OFFSET`=16'hFFFE.
  - `ZERO`=1 → next `IMEM_ADDR` = 3.
  - Repeated with `ZERO`=0 → next `IMEM_ADDR` = 6.
- **BNZ and JMR:**
  - PC=10, `MODE_SET`=1, `ZERO`=0, `IMM_OFFSET`=4 → next address 14.
  - `MODE_SET`=3, `OFFSET_SEL`=1, `REG_A`=16'h0010 → next address 16'h001A.
- **Wrap and jump:**
  - PC=16'hFFFF with `J`=0 → next address 0.
  - PC=16'hFFF0 with JMP and `IMM_OFFSET`=16'h0020 → next address 16'h0010.
- **Memory stall, stray valid and hold:**
  - `IMEM_VALID` delayed 4 cycles → unit stays in WAIT, and `OP_VALID` rises exactly once.
  - Stray `IMEM_VALID` in EXEC → no state change.
  - `HOLD`=1 in FETCH for 3 cycles → no `IMEM_REQ` during those cycles.
- **Reset during WAIT:** assert `RST` while in WAIT → next cycle state = FETCH, PC = `RESET_PC`, `OP_VALID` = 0, no EXEC for the abandoned fetch.
